// File: rtl/bram_port_scheduler.sv
// rtl/bram_port_scheduler.sv - round-robin burst scheduler sharing one BRAM controller port
//
// Shares one BRAM controller port among NUM_REQ requesters. It issues at most one access
// per cycle. A requester that keeps its request up holds the port for up to BURST_MAX
// back-to-back beats. Read data is steered back to the issuing requester by a tag
// pipeline whose length matches the controller read latency.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   req_valid       per-requester request valid
//   req_ready       one-hot grant (handshake = req_valid & req_ready)
//   req_wr          per-requester direction, 1 = write
//   req_addr        packed request addresses, requester i at [i*ADDR_W +: ADDR_W]
//   req_wdata       packed write data, requester i at [i*DATA_W +: DATA_W]
//   rsp_valid       one-hot read-return strobe
//   rsp_data        read data (pass-through of bram_do)
//   bram_stall      controller busy; no grant is issued
//   bram_in_valid   access strobe to controller
//   bram_wr         access direction
//   bram_addr       access address
//   bram_di         access write data
//   bram_do         read data from controller
//   bram_do_valid   read data strobe from controller
//   grant_id        current/last burst owner
//   lat_err         sticky: bram_do_valid disagreed with the tag pipeline
module bram_port_scheduler #(
  parameter int NUM_REQ   = 4,
  parameter int ADDR_W    = 13,
  parameter int DATA_W    = 32,
  parameter int READ_LAT  = 2,
  parameter int BURST_MAX = 4,
  localparam int ID_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int CNT_W    = $clog2(BURST_MAX + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ-1:0]        req_wr,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  input  logic                      bram_stall,
  output logic                      bram_in_valid,
  output logic                      bram_wr,
  output logic [ADDR_W-1:0]         bram_addr,
  output logic [DATA_W-1:0]         bram_di,
  input  logic [DATA_W-1:0]         bram_do,
  input  logic                      bram_do_valid,
  output logic [ID_W-1:0]           grant_id,
  output logic                      lat_err
);

  localparam logic [ID_W-1:0]  LAST_ID   = ID_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] BURST_END = CNT_W'(BURST_MAX);

  function automatic logic [ID_W-1:0] inc_id(input logic [ID_W-1:0] i);
    return (i == LAST_ID) ? '0 : i + ID_W'(1);
  endfunction

  logic [ID_W-1:0]    ptr;
  logic [ID_W-1:0]    owner;
  logic [ID_W-1:0]    sel;
  logic [ID_W-1:0]    base;
  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   next_cnt;
  logic               burst_live;
  logic               found;
  logic               hs;
  logic [NUM_REQ-1:0] iss_tag;
  logic [READ_LAT-1:0] vld_pipe;
  logic [NUM_REQ-1:0] tag_pipe [READ_LAT];

  // A nonzero count means a burst is in progress. If the owner has dropped its request,
  // the search starts just past the owner. This matches the pointer that the release
  // will store, so the release takes effect in the same cycle.
  assign burst_live = (count != '0);
  assign base       = burst_live ? inc_id(owner) : ptr;

  always_comb begin
    int j;
    j     = 0;
    sel   = base;
    found = 1'b0;
    if (burst_live && req_valid[owner]) begin
      sel   = owner;
      found = 1'b1;
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        j = (int'(base) + k) % NUM_REQ;
        if (!found && req_valid[j]) begin
          sel   = ID_W'(j);
          found = 1'b1;
        end
      end
    end
  end

  // Gating with rst_n keeps the grant low while reset is held, even with requests pending.
  assign hs       = found & ~bram_stall & rst_n;
  assign next_cnt = (burst_live && sel == owner) ? count + CNT_W'(1) : CNT_W'(1);

  always_comb begin
    req_ready = '0;
    if (hs) req_ready[sel] = 1'b1;
  end

  assign rsp_valid = vld_pipe[READ_LAT-1] ? tag_pipe[READ_LAT-1] : '0;
  assign rsp_data  = bram_do;
  assign grant_id  = owner;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr           <= '0;
      owner         <= '0;
      count         <= '0;
      bram_in_valid <= 1'b0;
      bram_wr       <= 1'b0;
      bram_addr     <= '0;
      bram_di       <= '0;
      iss_tag       <= '0;
      vld_pipe      <= '0;
      for (int k = 0; k < READ_LAT; k++) tag_pipe[k] <= '0;
      lat_err       <= 1'b0;
    end else begin
      if (hs) begin
        owner <= sel;
        if (next_cnt == BURST_END) begin
          count <= '0;
          ptr   <= inc_id(sel);
        end else begin
          count <= next_cnt;
        end
      end else if (!bram_stall && burst_live && !req_valid[owner]) begin
        count <= '0;
        ptr   <= inc_id(owner);
      end

      bram_in_valid <= hs;
      if (hs) begin
        bram_wr   <= req_wr[sel];
        bram_addr <= req_addr[int'(sel)*ADDR_W +: ADDR_W];
        bram_di   <= req_wdata[int'(sel)*DATA_W +: DATA_W];
      end
      iss_tag <= req_ready;

      // The issue register acts as the stage ahead of the pipeline. The head therefore
      // lines up with the controller's read strobe READ_LAT cycles after bram_in_valid.
      vld_pipe[0] <= bram_in_valid & ~bram_wr;
      tag_pipe[0] <= iss_tag;
      for (int k = 1; k < READ_LAT; k++) begin
        vld_pipe[k] <= vld_pipe[k-1];
        tag_pipe[k] <= tag_pipe[k-1];
      end

      if (bram_do_valid != vld_pipe[READ_LAT-1]) lat_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bram_port_scheduler.sv
// tb/tb_bram_port_scheduler.sv - directed self-checking bench for bram_port_scheduler
module tb_bram_port_scheduler;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [3:0]   rv = '0;
  logic [3:0]   rw = '0;
  logic [51:0]  raddr = '0;
  logic [127:0] rwd = '0;
  logic         stall = 1'b0;
  logic         inject = 1'b0;

  logic [3:0]   req_ready;
  logic [3:0]   rsp_valid;
  logic [31:0]  rsp_data;
  logic         bram_in_valid;
  logic         bram_wr;
  logic [12:0]  bram_addr;
  logic [31:0]  bram_di;
  logic [31:0]  bram_do;
  logic         bram_do_valid;
  logic [1:0]   grant_id;
  logic         lat_err;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bram_port_scheduler dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (rv),
    .req_ready     (req_ready),
    .req_wr        (rw),
    .req_addr      (raddr),
    .req_wdata     (rwd),
    .rsp_valid     (rsp_valid),
    .rsp_data      (rsp_data),
    .bram_stall    (stall),
    .bram_in_valid (bram_in_valid),
    .bram_wr       (bram_wr),
    .bram_addr     (bram_addr),
    .bram_di       (bram_di),
    .bram_do       (bram_do),
    .bram_do_valid (bram_do_valid),
    .grant_id      (grant_id),
    .lat_err       (lat_err)
  );

  // BRAM controller model: two-cycle read latency, writes land at the end of the issue cycle.
  logic [31:0] mem [256];
  logic        loaded = 1'b0;
  logic [1:0]  dv_pipe = '0;
  logic [31:0] dd0 = '0;
  logic [31:0] dd1 = '0;

  function automatic logic [31:0] memval(input int a);
    return 32'hA500_0000 | 32'(a);
  endfunction

  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < 256; i++) mem[i] <= memval(i);
      loaded <= 1'b1;
    end else if (bram_in_valid && bram_wr) begin
      mem[bram_addr[7:0]] <= bram_di;
    end
    dv_pipe <= {dv_pipe[0], bram_in_valid & ~bram_wr};
    dd0     <= mem[bram_addr[7:0]];
    dd1     <= dd0;
  end

  assign bram_do       = dd1;
  assign bram_do_valid = dv_pipe[1] | inject;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int grp(input int k);
    return (k / 4) % 4;
  endfunction

  initial begin
    // Reset with every requester asking for a read.
    rv = 4'b1111;
    rw = 4'b0000;
    for (int i = 0; i < 4; i++) raddr[i*13 +: 13] = 13'(32'h40 + i);
    tick();
    tick();
    tick();
    #1;
    check("rst_ready", 64'(req_ready), 64'h0);
    check("rst_in_valid", 64'(bram_in_valid), 64'h0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'h0);
    check("rst_grant_id", 64'(grant_id), 64'h0);
    check("rst_lat_err", 64'(lat_err), 64'h0);
    check("rst_addr", 64'(bram_addr), 64'h0);

    // Release reset; all four read continuously: grants go 0x4, 1x4, 2x4, 3x4, 0x4.
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      #1;
      check("rr_ready", 64'(req_ready), 64'(4'b0001 << grp(k)));
      if (k == 0) begin
        check("rr_first_in_valid", 64'(bram_in_valid), 64'h0);
      end else begin
        check("rr_in_valid", 64'(bram_in_valid), 64'h1);
        check("rr_addr", 64'(bram_addr), 64'(32'h40 + grp(k - 1)));
      end
      if (k >= 3) begin
        check("rr_rsp_valid", 64'(rsp_valid), 64'(4'b0001 << grp(k - 3)));
        check("rr_rsp_data", 64'(rsp_data), 64'(memval(32'h40 + grp(k - 3))));
      end else begin
        check("rr_rsp_idle", 64'(rsp_valid), 64'h0);
      end
      tick();
    end
    rv = 4'b0000;
    tick();
    tick();
    tick();
    tick();
    #1;
    check("rr_drained", 64'(rsp_valid), 64'h0);
    check("rr_lat_err", 64'(lat_err), 64'h0);

    // Burst release: req 2 alone for two beats, then req 1 and req 3 take over -> req 3.
    rv = 4'b0100;
    #1;
    check("br_beat1", 64'(req_ready), 64'h4);
    tick();
    #1;
    check("br_beat2", 64'(req_ready), 64'h4);
    tick();
    rv = 4'b1010;
    #1;
    check("br_next_is_3", 64'(req_ready), 64'h8);
    tick();
    #1;
    check("br_owner3_keeps", 64'(req_ready), 64'h8);
    check("br_grant_id", 64'(grant_id), 64'h3);
    rv = 4'b0000;
    tick();
    tick();
    tick();
    tick();

    // Stall: req 0 starts a burst, then five stalled cycles, then req 0 resumes.
    rv = 4'b0011;
    #1;
    check("st_first", 64'(req_ready), 64'h1);
    tick();
    stall = 1'b1;
    for (int s = 0; s < 5; s++) begin
      #1;
      check("st_ready", 64'(req_ready), 64'h0);
      check("st_in_valid", 64'(bram_in_valid), (s == 0) ? 64'h1 : 64'h0);
      check("st_grant_id", 64'(grant_id), 64'h0);
      tick();
    end
    stall = 1'b0;
    #1;
    check("st_resume_owner", 64'(req_ready), 64'h1);
    tick();
    rv = 4'b0000;
    #1;
    check("st_resume_issue", 64'(bram_in_valid), 64'h1);
    tick();
    tick();
    tick();
    tick();

    // Mixed R/W: req 3 writes 0xDEADBEEF to 0x0010, req 0 reads it on the next cycle.
    rv = 4'b1000;
    rw = 4'b1000;
    raddr[3*13 +: 13] = 13'h0010;
    rwd[3*32 +: 32]   = 32'hDEADBEEF;
    #1;
    check("mx_wr_grant", 64'(req_ready), 64'h8);
    tick();
    rv = 4'b0001;
    rw = 4'b0000;
    raddr[0 +: 13] = 13'h0010;
    #1;
    check("mx_rd_grant", 64'(req_ready), 64'h1);
    check("mx_wr_issue", 64'(bram_in_valid), 64'h1);
    check("mx_wr_dir", 64'(bram_wr), 64'h1);
    check("mx_wr_addr", 64'(bram_addr), 64'h10);
    check("mx_wr_data", 64'(bram_di), 64'hDEADBEEF);
    tick();
    rv = 4'b0000;
    #1;
    check("mx_rd_issue", 64'(bram_in_valid), 64'h1);
    check("mx_rd_dir", 64'(bram_wr), 64'h0);
    tick();
    #1;
    check("mx_no_wr_rsp", 64'(rsp_valid), 64'h0);
    tick();
    #1;
    check("mx_rd_rsp", 64'(rsp_valid), 64'h1);
    check("mx_rd_data", 64'(rsp_data), 64'hDEADBEEF);
    check("mx_lat_err", 64'(lat_err), 64'h0);
    tick();
    tick();

    // Reset with two reads outstanding: nothing may come back after release.
    rv = 4'b0011;
    raddr[0 +: 13]  = 13'h0041;
    raddr[13 +: 13] = 13'h0041;
    #1;
    check("rm_grant", 64'(req_ready), 64'h2);
    tick();
    tick();
    rv = 4'b0000;
    rst_n = 1'b0;
    #1;
    check("rm_in_valid", 64'(bram_in_valid), 64'h0);
    check("rm_rsp", 64'(rsp_valid), 64'h0);
    tick();
    tick();
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      check("rm_no_rsp", 64'(rsp_valid), 64'h0);
      check("rm_no_err", 64'(lat_err), 64'h0);
      tick();
    end

    // A read strobe with an empty tag pipeline sets lat_err permanently.
    inject = 1'b1;
    tick();
    inject = 1'b0;
    #1;
    check("le_set", 64'(lat_err), 64'h1);
    check("le_no_rsp", 64'(rsp_valid), 64'h0);
    tick();
    tick();
    #1;
    check("le_sticky", 64'(lat_err), 64'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
